// File: rtl/bp_pkg.sv
// Shared types and default constants for the perceptron training controller.
package bp_pkg;

  localparam int THETA_DEFAULT     = 38;
  localparam int CHUNK_LEN_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_READ   = 2'd1,
    ST_DECIDE = 2'd2,
    ST_WRITE  = 2'd3
  } train_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic        taken;
  } br_entry_t;

  localparam int ENTRY_W = $bits(br_entry_t);

endpackage

// File: rtl/bp_train_fifo.sv
// Resolved-branch queue; fullness comes from the registered count, so a push
// while full is dropped even if a pop happens in the same cycle.
module bp_train_fifo
  import bp_pkg::*;
#(
  parameter int QDepth = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               push_i,
  input  logic [ENTRY_W-1:0] entry_i,
  input  logic               pop_i,
  output logic [ENTRY_W-1:0] head_o,
  output logic               empty_o,
  output logic               full_o
);

  localparam int AW = (QDepth > 1) ? $clog2(QDepth) : 1;
  localparam logic [AW:0] FullCnt = (AW+1)'(QDepth);

  logic [ENTRY_W-1:0] mem_r [QDepth];
  logic [AW-1:0]      wr_ptr_r, rd_ptr_r;
  logic [AW:0]        count_r;
  logic               push_s, pop_s;

  assign full_o  = (count_r == FullCnt);
  assign empty_o = (count_r == '0);
  assign push_s  = push_i & ~full_o;
  assign pop_s   = pop_i & ~empty_o;
  assign head_o  = mem_r[rd_ptr_r];

  // Storage needs no reset: the count alone says which slots are live.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= entry_i;
    end
  end

  // Pointers and occupancy count.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + 1'b1;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/bp_train_ctrl.sv
// Perceptron training sequencer: queue -> READ -> DECIDE -> chunked WRITE.
// Define BP_TRAIN_ALWAYS_EN to train on every resolved branch regardless of the sum.
module bp_train_ctrl
  import bp_pkg::*;
#(
  parameter int PTableSize = 1024,
  parameter int GHRLen     = 12,
  parameter int ChunkLen   = CHUNK_LEN_DEFAULT,
  parameter int QDepth     = 4,
  parameter int Theta      = THETA_DEFAULT,
  parameter int SumW       = 16,
  localparam int IW        = $clog2(PTableSize),
  localparam int NumChunks = (GHRLen + ChunkLen - 1) / ChunkLen,
  localparam int CW        = (NumChunks > 1) ? $clog2(NumChunks) : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                ex_br_valid_i,
  input  logic                ex_br_taken_i,
  input  logic [31:0]         ex_br_instr_addr_i,
  input  logic                fetch_req_i,
  output logic                tbl_rd_o,
  output logic                tbl_we_o,
  output logic [IW-1:0]       tbl_index_o,
  output logic [CW-1:0]       tbl_chunk_o,
  output logic [ChunkLen-1:0] tbl_inc_o,
  output logic                tbl_bias_inc_o,
  input  logic [SumW-1:0]     tbl_sum_i,
  output logic [GHRLen-1:0]   ghr_o,
  output logic                q_full_o,
  output logic                busy_o
);

  localparam int PadW = NumChunks * ChunkLen;
  localparam logic [CW-1:0] LastChunk = CW'(NumChunks - 1);

  train_state_e        state_r, state_s;
  logic [CW-1:0]       chunk_r, chunk_s;
  logic [GHRLen-1:0]   ghr_r, ghr_s;
  logic [ENTRY_W-1:0]  head_vec_s;
  br_entry_t           head_s;
  logic                q_empty_s, pop_s, train_s, rd_s, we_s;
  logic [ChunkLen-1:0] hist_chunk_s, lane_valid_s;
  logic                unused_s;

  bp_train_fifo #(.QDepth(QDepth)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (ex_br_valid_i),
    .entry_i ({ex_br_instr_addr_i, ex_br_taken_i}),
    .pop_i   (pop_s),
    .head_o  (head_vec_s),
    .empty_o (q_empty_s),
    .full_o  (q_full_o)
  );

  assign head_s = br_entry_t'(head_vec_s);

  // History bits of the current chunk; lanes past GHRLen are masked off.
  assign hist_chunk_s = ChunkLen'(PadW'(ghr_r) >> (int'(chunk_r) * ChunkLen));
  assign lane_valid_s = ChunkLen'(PadW'({GHRLen{1'b1}}) >> (int'(chunk_r) * ChunkLen));

`ifdef BP_TRAIN_ALWAYS_EN
  assign train_s  = 1'b1;
  assign unused_s = ^{head_s.addr[31:IW+2], head_s.addr[1:0], tbl_sum_i};
`else
  logic [SumW-1:0] abs_sum_s;

  // Saturating magnitude of the sum, then mispredict-or-low-confidence test.
  always_comb begin
    if (tbl_sum_i == {1'b1, {(SumW-1){1'b0}}}) begin
      abs_sum_s = {1'b0, {(SumW-1){1'b1}}};
    end else if (tbl_sum_i[SumW-1]) begin
      abs_sum_s = ~tbl_sum_i + 1'b1;
    end else begin
      abs_sum_s = tbl_sum_i;
    end
    train_s = (head_s.taken == tbl_sum_i[SumW-1]) | (abs_sum_s < SumW'(Theta));
  end

  assign unused_s = ^{head_s.addr[31:IW+2], head_s.addr[1:0]};
`endif

  // Next state, table strobes (fetch always wins the port) and retirement.
  always_comb begin
    state_s = state_r;
    chunk_s = chunk_r;
    ghr_s   = ghr_r;
    pop_s   = 1'b0;
    rd_s    = 1'b0;
    we_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!q_empty_s) state_s = ST_READ;
        else            state_s = ST_IDLE;
      end
      ST_READ: begin
        if (!fetch_req_i) begin
          rd_s    = 1'b1;
          state_s = ST_DECIDE;
        end else begin
          state_s = ST_READ;
        end
      end
      ST_DECIDE: begin
        if (train_s) begin
          chunk_s = '0;
          state_s = ST_WRITE;
        end else begin
          pop_s   = 1'b1;
          ghr_s   = {ghr_r[GHRLen-2:0], head_s.taken};
          state_s = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (!fetch_req_i) begin
          we_s = 1'b1;
          if (chunk_r == LastChunk) begin
            pop_s   = 1'b1;
            ghr_s   = {ghr_r[GHRLen-2:0], head_s.taken};
            chunk_s = '0;
            state_s = ST_IDLE;
          end else begin
            chunk_s = chunk_r + 1'b1;
          end
        end else begin
          state_s = ST_WRITE;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Outputs are held at zero while reset is asserted, even mid-sequence.
  always_comb begin
    tbl_rd_o       = 1'b0;
    tbl_we_o       = 1'b0;
    busy_o         = 1'b0;
    tbl_index_o    = '0;
    tbl_chunk_o    = '0;
    tbl_inc_o      = '0;
    tbl_bias_inc_o = 1'b0;
    if (rst_ni) begin
      tbl_rd_o = rd_s;
      tbl_we_o = we_s;
      busy_o   = (state_r != ST_IDLE);
      if (state_r != ST_IDLE) tbl_index_o = head_s.addr[IW+1:2];
      else                    tbl_index_o = '0;
      if (state_r == ST_WRITE) begin
        tbl_chunk_o    = chunk_r;
        tbl_inc_o      = lane_valid_s & ~({ChunkLen{head_s.taken}} ^ hist_chunk_s);
        tbl_bias_inc_o = head_s.taken;
      end else begin
        tbl_chunk_o    = '0;
        tbl_inc_o      = '0;
        tbl_bias_inc_o = 1'b0;
      end
    end else begin
      tbl_rd_o = 1'b0;
      tbl_we_o = 1'b0;
    end
  end

  assign ghr_o = ghr_r;

  // State, chunk counter and committed history.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_r <= ST_IDLE;
      chunk_r <= '0;
      ghr_r   <= '0;
    end else begin
      state_r <= state_s;
      chunk_r <= chunk_s;
      ghr_r   <= ghr_s;
    end
  end

endmodule

// File: tb/tb_bp_train_ctrl.sv
// Bench for bp_train_ctrl: directed scenarios, then random traffic checked
// against a transaction-level model (queue of branches + history word).
module tb_bp_train_ctrl;

  localparam int NUM_CHUNKS = 3;
  localparam int Q_DEPTH    = 4;
  localparam int THETA      = 38;

  logic        clk_i = 1'b0;
  logic        rst_ni, ex_br_valid_i, ex_br_taken_i, fetch_req_i;
  logic [31:0] ex_br_instr_addr_i;
  logic        tbl_rd_o, tbl_we_o, tbl_bias_inc_o, q_full_o, busy_o;
  logic [9:0]  tbl_index_o;
  logic [1:0]  tbl_chunk_o;
  logic [3:0]  tbl_inc_o;
  logic [15:0] tbl_sum_i;
  logic [11:0] ghr_o;

  bp_train_ctrl dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .ex_br_valid_i(ex_br_valid_i),
    .ex_br_taken_i(ex_br_taken_i), .ex_br_instr_addr_i(ex_br_instr_addr_i),
    .fetch_req_i(fetch_req_i), .tbl_rd_o(tbl_rd_o), .tbl_we_o(tbl_we_o),
    .tbl_index_o(tbl_index_o), .tbl_chunk_o(tbl_chunk_o), .tbl_inc_o(tbl_inc_o),
    .tbl_bias_inc_o(tbl_bias_inc_o), .tbl_sum_i(tbl_sum_i), .ghr_o(ghr_o),
    .q_full_o(q_full_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] addr;
    logic        taken;
    logic [15:0] sum;
  } ment_t;

  ment_t       mq[$];
  int          m_phase = 0;   // 0: awaiting read, 1: sum due now, 2: writing chunks
  int          m_chunk = 0;
  logic [11:0] m_ghr   = 12'h000;
  logic [15:0] in_sum  = 16'h0000;
  int          n_cmp   = 0;
  int          n_err   = 0;

  logic        s_rd, s_we, s_bias, s_full, s_busy;
  logic [9:0]  s_idx;
  logic [1:0]  s_chunk;
  logic [3:0]  s_inc;
  logic [11:0] s_ghr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] idx_of(input logic [31:0] addr);
    return (addr >> 2) & 32'd1023;
  endfunction

  function automatic logic exp_train(input logic taken, input logic [15:0] sum);
    int s, mag;
    s   = int'($signed(sum));
    mag = (s < 0) ? -s : s;
    if (mag > 32767) mag = 32767;
    return ((taken == 1'b1) != (s >= 0)) || (mag < THETA);
  endfunction

  function automatic logic [3:0] exp_inc(input logic taken, input int c, input logic [11:0] ghr);
    logic [3:0] r;
    int idx;
    r = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      idx = c * 4 + k;
      if (idx < 12) r[k] = (taken == ghr[idx]);
    end
    return r;
  endfunction

  function automatic logic [15:0] rand_sum();
    case ($urandom_range(0, 5))
      0:       return 16'h8000;
      1:       return 16'($urandom_range(0, 1) ? 38 : 37);
      2:       return 16'(-int'($urandom_range(36, 39)));
      3:       return 16'($urandom());
      default: return 16'(int'($urandom_range(0, 400)) - 200);
    endcase
  endfunction

  task automatic set_push(input logic [31:0] a, input logic t, input logic [15:0] s);
    ex_br_valid_i = 1'b1; ex_br_instr_addr_i = a; ex_br_taken_i = t; in_sum = s;
  endtask

  task automatic clr_push();
    ex_br_valid_i = 1'b0; ex_br_instr_addr_i = 32'h0; ex_br_taken_i = 1'b0;
  endtask

  // One clock: supply the sum in the cycle after a read, sample, check, update model.
  task automatic cycle();
    bit do_pop, do_push;
    ment_t e;
    do_pop = 1'b0; do_push = 1'b0;
    if (m_phase == 1 && mq.size() > 0) tbl_sum_i = mq[0].sum;
    else                               tbl_sum_i = 16'($urandom());
    @(negedge clk_i);
    s_rd = tbl_rd_o; s_we = tbl_we_o; s_idx = tbl_index_o; s_chunk = tbl_chunk_o;
    s_inc = tbl_inc_o; s_bias = tbl_bias_inc_o; s_full = q_full_o; s_busy = busy_o;
    s_ghr = ghr_o;
    if (!rst_ni) begin
      chk("reset_strobes", 32'({s_rd, s_we}), 32'd0);
    end else begin
      chk("rd_and_we", 32'(s_rd & s_we), 32'd0);
      chk("strobe_during_fetch", 32'((s_rd | s_we) & fetch_req_i), 32'd0);
      chk("q_full", 32'(s_full), 32'(mq.size() == Q_DEPTH));
      chk("ghr", 32'(s_ghr), 32'(m_ghr));
      if (m_phase == 1) begin
        chk("decide_quiet", 32'({s_rd, s_we}), 32'd0);
        if (exp_train(mq[0].taken, mq[0].sum)) begin
          m_phase = 2; m_chunk = 0;
        end else begin
          do_pop = 1'b1; m_phase = 0;
        end
      end else if (m_phase == 2) begin
        chk("write_no_rd", 32'(s_rd), 32'd0);
        if (s_we) begin
          chk("we_index", 32'(s_idx), idx_of(mq[0].addr));
          chk("we_chunk", 32'(s_chunk), 32'(m_chunk));
          chk("we_bias", 32'(s_bias), 32'(mq[0].taken));
          chk("we_inc", 32'(s_inc), 32'(exp_inc(mq[0].taken, m_chunk, m_ghr)));
          m_chunk++;
          if (m_chunk == NUM_CHUNKS) begin
            do_pop = 1'b1; m_phase = 0;
          end
        end
      end else begin
        chk("no_we_outside_write", 32'(s_we), 32'd0);
        if (s_rd) begin
          chk("rd_has_entry", 32'(mq.size() > 0), 32'd1);
          if (mq.size() > 0) begin
            chk("rd_index", 32'(s_idx), idx_of(mq[0].addr));
            m_phase = 1;
          end
        end
      end
      do_push = ex_br_valid_i && (mq.size() < Q_DEPTH);
      e.addr = ex_br_instr_addr_i; e.taken = ex_br_taken_i; e.sum = in_sum;
    end
    @(posedge clk_i);
    if (!rst_ni) begin
      mq.delete(); m_ghr = 12'h000; m_phase = 0; m_chunk = 0;
    end else begin
      if (do_pop) begin
        m_ghr = {m_ghr[10:0], mq[0].taken};
        void'(mq.pop_front());
      end
      if (do_push) mq.push_back(e);
    end
    #1;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 300; i++) begin
      if (mq.size() > 0 || m_phase != 0) cycle();
    end
    chk(tag, 32'(mq.size()), 32'd0);
  endtask

  initial begin
    rst_ni = 1'b0; fetch_req_i = 1'b0; tbl_sum_i = 16'h0000;
    clr_push();
    cycle(); cycle();
    rst_ni = 1'b1;
    cycle();
    chk("rst_busy", 32'(s_busy), 32'd0);
    chk("rst_full", 32'(s_full), 32'd0);
    chk("rst_ghr", 32'(s_ghr), 32'd0);
    chk("rst_index", 32'(s_idx), 32'd0);

    // Confident correct prediction: read only, history updated.
    set_push(32'h0000_0104, 1'b1, 16'd50); cycle(); clr_push();
    cycle(); chk("d1_idle_no_rd", 32'(s_rd), 32'd0);
    cycle(); chk("d1_rd", 32'(s_rd), 32'd1); chk("d1_index", 32'(s_idx), 32'h41);
    cycle(); chk("d1_no_we", 32'(s_we), 32'd0);
    cycle(); chk("d1_ghr", 32'(s_ghr), 32'h001); chk("d1_busy", 32'(s_busy), 32'd0);

    // Low-confidence sum: three chunk writes.
    set_push(32'h0000_0104, 1'b1, 16'd10); cycle(); clr_push();
    cycle(); cycle(); chk("d2_rd", 32'(s_rd), 32'd1);
    cycle();
    for (int c = 0; c < 3; c++) begin
      cycle();
      chk("d2_we", 32'(s_we), 32'd1);
      chk("d2_chunk", 32'(s_chunk), 32'(c));
      chk("d2_bias", 32'(s_bias), 32'd1);
      chk("d2_inc", 32'(s_inc), (c == 0) ? 32'h1 : 32'h0);
    end
    cycle(); chk("d2_ghr", 32'(s_ghr), 32'h003); chk("d2_busy", 32'(s_busy), 32'd0);

    // Mispredicted not-taken: bias decrements.
    set_push(32'h0000_0208, 1'b0, 16'd100); cycle(); clr_push();
    cycle(); cycle(); cycle();
    for (int c = 0; c < 3; c++) begin
      cycle();
      chk("d3_we", 32'(s_we), 32'd1);
      chk("d3_bias", 32'(s_bias), 32'd0);
      chk("d3_inc", 32'(s_inc), (c == 0) ? 32'hC : 32'hF);
    end
    cycle(); chk("d3_ghr", 32'(s_ghr), 32'h006);

    // Fetch holds the port for five cycles while the read is pending.
    set_push(32'h0000_030C, 1'b1, 16'd60); cycle(); clr_push();
    cycle();
    fetch_req_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle(); chk("d4_rd_blocked", 32'(s_rd), 32'd0); chk("d4_busy", 32'(s_busy), 32'd1);
    end
    fetch_req_i = 1'b0;
    cycle(); chk("d4_rd_granted", 32'(s_rd), 32'd1); chk("d4_index", 32'(s_idx), 32'hC3);
    cycle(); cycle(); chk("d4_ghr", 32'(s_ghr), 32'h00D);

    // Six back-to-back branches against a full queue.
    fetch_req_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_push(32'h0000_1000 + 32'(i * 4), 1'(i % 2), (i % 2) ? 16'd100 : 16'hFF9C);
      cycle();
      chk("d5_full_seq", 32'(s_full), 32'(i >= 4));
    end
    clr_push();
    cycle(); chk("d5_full_hold", 32'(s_full), 32'd1);
    fetch_req_i = 1'b0;
    drain("d5_drained");
    cycle(); chk("d5_ghr", 32'(s_ghr), 32'h0D5);

    // Reset in the middle of the chunk writes.
    set_push(32'h0000_0400, 1'b1, 16'd0); cycle(); clr_push();
    cycle(); cycle(); cycle();
    cycle(); chk("d6_we_chunk0", 32'({s_we, s_chunk}), 32'h4);
    rst_ni = 1'b0;
    cycle(); chk("d6_we_in_reset", 32'(s_we), 32'd0);
    rst_ni = 1'b1;
    cycle();
    chk("d6_busy", 32'(s_busy), 32'd0); chk("d6_full", 32'(s_full), 32'd0);
    chk("d6_ghr", 32'(s_ghr), 32'd0); chk("d6_we", 32'(s_we), 32'd0);
    cycle(); cycle(); cycle();

    // Random traffic with random fetch contention.
    for (int i = 0; i < 400; i++) begin
      fetch_req_i = ($urandom_range(0, 99) < 30);
      if ($urandom_range(0, 99) < 35) set_push($urandom(), 1'($urandom_range(0, 1)), rand_sum());
      else                            clr_push();
      cycle();
    end
    clr_push(); fetch_req_i = 1'b0;
    drain("rand_drained");
    cycle(); chk("rand_idle", 32'(s_busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bp_train_ctrl.md
BP_TRAIN_CTRL -- requirements
Module: bp_train_ctrl

Interface
REQ-001 Parameter PTableSize, default 1024: perceptron table entries; index width IW = log2(PTableSize).
REQ-002 Parameter GHRLen, default 12: global history length.
REQ-003 Parameter ChunkLen, default 4: weights written per write cycle; NumChunks = ceil(GHRLen/ChunkLen).
REQ-004 Parameter QDepth, default 4, power of two: resolved-branch queue depth.
REQ-005 Parameter Theta, default 38: training threshold on |yout|.
REQ-006 Parameter SumW, default 16: signed width of the perceptron sum.
REQ-007 clk_i  in  1  sole clock; one clock domain.
REQ-008 rst_ni  in  1  reset, synchronous, active-low.
REQ-009 ex_br_valid_i  in  1  resolved conditional branch from execute stage.
REQ-010 ex_br_taken_i  in  1  resolved direction.
REQ-011 ex_br_instr_addr_i  in  32  branch PC.
REQ-012 fetch_req_i  in  1  fetch-side prediction read wants the table port this cycle.
REQ-013 tbl_rd_o  out  1  training read of the entry at tbl_index_o.
REQ-014 tbl_we_o  out  1  write of chunk tbl_chunk_o at tbl_index_o.
REQ-015 tbl_index_o  out  IW  table index = addr[IW+1:2].
REQ-016 tbl_chunk_o  out  log2(NumChunks) (min 1)  weight chunk being written; chunk 0 also carries the bias.
REQ-017 tbl_inc_o  out  ChunkLen  per-weight direction: 1 = increment (taken == history bit), 0 = decrement.
REQ-018 tbl_bias_inc_o  out  1  bias direction, equals the trained branch's taken bit.
REQ-019 tbl_sum_i  in  SumW  signed perceptron sum, valid the cycle after a granted tbl_rd_o.
REQ-020 ghr_o  out  GHRLen  committed global history, bit 0 newest.
REQ-021 q_full_o  out  1  queue full; busy_o  out  1  FSM not in IDLE.

Function
REQ-022 Queue SHALL enqueue {addr, taken} when ex_br_valid_i & ~q_full_o; an input while full SHALL be dropped with no state change.
REQ-023 Fullness SHALL be decided from the registered count; enqueue and dequeue in the same cycle SHALL leave the count unchanged.
REQ-024 FSM states IDLE, READ, DECIDE, WRITE; IDLE->READ when queue non-empty.
REQ-025 READ SHALL assert tbl_rd_o only while fetch_req_i is low; fetch has absolute priority; the FSM holds in READ until granted.
REQ-026 DECIDE (cycle after grant) SHALL sample tbl_sum_i; train = (taken != (sum >= 0)) | (|sum| < Theta), |sum| saturating at 2^(SumW-1)-1 for the most negative value.
REQ-027 If train, DECIDE->WRITE, chunk counter = 0; else dequeue, shift GHR, ->IDLE.
REQ-028 WRITE SHALL assert tbl_we_o only while fetch_req_i is low, advancing the chunk after each granted write; tbl_inc_o[k] = ~(taken ^ ghr[chunk*ChunkLen+k]); lanes beyond GHRLen SHALL drive 0 and are ignored.
REQ-029 After the last granted chunk: dequeue, GHR <= {GHR[GHRLen-2:0], taken}, ->IDLE; uncontested latency from enqueue to last write = 3 + NumChunks cycles.
REQ-030 GHR SHALL be stable for the whole READ..WRITE sequence of one entry.
REQ-031 tbl_rd_o and tbl_we_o SHALL never both be high and SHALL never be high while fetch_req_i is high.

Reset
REQ-032 Reset SHALL clear the queue, GHR and chunk counter and force IDLE; every output SHALL be 0 during and after reset until new input.
REQ-033 Reset mid-sequence SHALL abandon the in-flight entry without completing its remaining chunk writes.

Configuration
REQ-034 With BP_TRAIN_ALWAYS_EN defined, DECIDE SHALL always choose train (threshold and misprediction ignored; tbl_sum_i unused); without it, REQ-026 applies.

Structure
REQ-035 A shared package bp_pkg SHALL hold the FSM state enum, the queue-entry struct {addr, taken} and the default Theta/ChunkLen constants.
REQ-036 The queue SHALL be one sub-module, bp_train_fifo; FSM, GHR and chunk sequencing stay in bp_train_ctrl.

Verification
REQ-037 Enqueue addr 0x0000_0104, taken=1, sum=+50, fetch idle -> tbl_rd_o at t+1 index 0x041, no tbl_we_o, ghr_o bit0=1 at t+3.
REQ-038 Same entry, sum=+10 -> tbl_we_o chunks 0,1,2 at t+3..t+5, tbl_bias_inc_o=1, tbl_inc_o matches ghr_o per chunk.
REQ-039 taken=0, sum=+100 (mispredict) -> training writes all chunks with tbl_bias_inc_o=0.
REQ-040 fetch_req_i high for 5 cycles during READ -> tbl_rd_o held low, issued the first cycle fetch_req_i drops; no cycle with both high.
REQ-041 Six back-to-back ex_br_valid_i with fetch held high -> q_full_o after 4, entries 5-6 dropped, first 4 later processed in order.
REQ-042 Assert rst_ni low during WRITE chunk 1 -> next cycle busy_o=0, q_full_o=0, ghr_o=0, no further tbl_we_o.
